// File: rtl/frame_loader_pkg.sv
// Shared state encoding and sync-word constants for the UART frame loader.
package frame_loader_pkg;

  typedef enum logic [1:0] {
    HUNT0   = 2'd0,
    HUNT1   = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_e;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
    return 8'(acc + b);
  endfunction

endpackage

// File: rtl/byte_strobe.sv
// Rising-edge detector turning the receiver's byte-valid level into a single-cycle strobe.
module byte_strobe (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic pulse_out
);

  logic level_q;

  // History resets high so a level already asserted at reset release is not taken as a byte.
  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b1;
    else     level_q <= level_in;
  end

  assign pulse_out = level_in & ~level_q;

endmodule

// File: rtl/uart_frame_loader.sv
// Hunts for the A5 5A sync word, streams one frame of payload into the back bank of a
// double-buffered frame RAM and swaps banks only when the trailing checksum matches.
module uart_frame_loader
  import frame_loader_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 600,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_ack,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [7:0]        wr_data,
  output logic              disp_bank,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              bank_q, bank_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              byte_stb;

  byte_strobe u_strobe (
    .clk       (clk),
    .rst       (rst),
    .level_in  (rx_ack),
    .pulse_out (byte_stb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT0;
      idx_q     <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      bank_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      tmo_q     <= tmo_d;
      bank_q    <= bank_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    tmo_d     = tmo_q;
    bank_d    = bank_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      HUNT0: begin
        if (byte_stb && rx_data == SYNC0) state_d = HUNT1;
      end

      HUNT1: begin
        if (byte_stb) begin
          if (rx_data == SYNC1) begin
            state_d = PAYLOAD;
            idx_d   = '0;
            sum_d   = '0;
            tmo_d   = '0;
          end else if (rx_data != SYNC0) begin
            state_d = HUNT0;
          end
        end
      end

      PAYLOAD: begin
        if (byte_stb) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {~bank_q, idx_q};
          wr_data_d = rx_data;
          sum_d     = sum_add(sum_q, rx_data);
          tmo_d     = '0;
          // Index parks on the last slot so it never points past the frame.
          if (idx_q == IDX_LAST) state_d = CHECK;
          else                   idx_d   = ADDR_W'(idx_q + ADDR_W'(1));
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = HUNT0;
        end else begin
          tmo_d = TMO_W'(tmo_q + TMO_W'(1));
        end
      end

      CHECK: begin
        if (byte_stb) begin
          if (rx_data == sum_q) begin
            done_d = 1'b1;
            bank_d = ~bank_q;
          end else begin
            err_d  = 1'b1;
          end
          tmo_d   = '0;
          state_d = HUNT0;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = HUNT0;
        end else begin
          tmo_d = TMO_W'(tmo_q + TMO_W'(1));
        end
      end

      default: state_d = HUNT0;
    endcase
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign disp_bank  = bank_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed-sequence bench with randomized payloads, holds and gaps, checked against
// expectations derived from the frame format (write list, checksum, bank swap rules).
module tb_uart_frame_loader;

  localparam int unsigned FB  = 600;
  localparam int unsigned AW  = 10;
  localparam int unsigned TMO = 1000;

  logic          clk;
  logic          rst;
  logic          rx_ack;
  logic [7:0]    rx_data;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [7:0]    wr_data;
  logic          disp_bank;
  logic          frame_done;
  logic          frame_err;

  uart_frame_loader #(
    .FRAME_BYTES (FB),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .disp_bank  (disp_bank),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  pay [FB];
  logic [18:0] wq [$];
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          excl_viol = 0;
  int          hold_viol = 0;
  logic        rst_at_edge = 1'b1;
  logic [AW:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;
  logic        exp_bank;

  always @(posedge clk) rst_at_edge <= rst;

  // Passive monitor: logs writes and pulses, and tracks exclusivity and hold behaviour.
  always @(negedge clk) begin
    if (wr_en) wq.push_back({wr_addr, wr_data});
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if ((int'(wr_en) + int'(frame_done) + int'(frame_err)) > 1) excl_viol++;
    if (!rst_at_edge && !wr_en && (wr_addr !== prev_addr || wr_data !== prev_data)) hold_viol++;
    prev_addr = wr_addr;
    prev_data = wr_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge clk);
    rx_data = b;
    rx_ack  = 1'b1;
    repeat (hold) @(negedge clk);
    rx_ack = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_payload(input int n, input int hold_fixed);
    for (int i = 0; i < n; i++) begin
      int h;
      h = (hold_fixed > 0) ? hold_fixed : int'($urandom_range(1, 3));
      send_byte(pay[i], h, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic fill_pay(input bit counting);
    for (int i = 0; i < FB; i++)
      pay[i] = counting ? 8'(i % 256) : 8'($urandom_range(0, 255));
  endtask

  function automatic logic [7:0] pay_sum();
    int s = 0;
    for (int i = 0; i < FB; i++) s += int'(pay[i]);
    return 8'(s % 256);
  endfunction

  // Expected write list: n bytes to consecutive indices of one bank, in order.
  task automatic check_writes(input string tag, input int n, input logic bank);
    int mism = 0;
    check({tag, "_count"}, 32'(wq.size()), 32'(n));
    for (int i = 0; i < n && i < wq.size(); i++)
      if (wq[i] !== {bank, AW'(i), pay[i]}) mism++;
    check({tag, "_content"}, 32'(mism), 32'd0);
    wq.delete();
  endtask

  task automatic check_events(input string tag, input int d, input int e, input logic bank);
    check({tag, "_done"}, 32'(done_cnt), 32'(d));
    check({tag, "_err"}, 32'(err_cnt), 32'(e));
    check({tag, "_bank"}, 32'(disp_bank), 32'(bank));
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic good_frame(input string tag, input int hold_fixed);
    send_payload(FB, hold_fixed);
    send_byte(pay_sum(), 1, 1);
    repeat (3) @(negedge clk);
    check_writes(tag, FB, ~exp_bank);
    exp_bank = ~exp_bank;
    check_events(tag, 1, 0, exp_bank);
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    rx_ack = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_disp_bank", 32'(disp_bank), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    exp_bank = 1'b0;
    wq.delete();
    done_cnt = 0;
    err_cnt = 0;

    // Bad checksum: full write, error pulse, no swap.
    fill_pay(1'b1);
    send_byte(8'hA5, 1, 0);
    send_byte(8'h5A, 1, 0);
    send_payload(FB, 0);
    send_byte(pay_sum() ^ 8'h01, 1, 1);
    repeat (3) @(negedge clk);
    check_writes("badsum", FB, 1'b1);
    check_events("badsum", 0, 1, 1'b0);

    // Timeout after 100 payload bytes.
    fill_pay(1'b0);
    send_byte(8'hA5, 1, 0);
    send_byte(8'h5A, 1, 0);
    send_payload(99, 0);
    send_byte(pay[99], 1, 0);
    for (int i = 1; i <= int'(TMO) + 1; i++) begin
      @(negedge clk);
      if (i == int'(TMO) - 1) check("tmo_early", 32'(frame_err), 32'd0);
      if (i == int'(TMO))     check("tmo_fire", 32'(frame_err), 32'd1);
      if (i == int'(TMO) + 1) check("tmo_pulse", 32'(frame_err), 32'd0);
    end
    check_writes("tmo", 100, 1'b1);
    check_events("tmo", 0, 1, 1'b0);

    // Lone 5A must not sync from HUNT0; then the counting frame is accepted into bank 1.
    send_byte(8'h5A, 1, 1);
    fill_pay(1'b1);
    send_byte(8'hA5, 1, 0);
    send_byte(8'h5A, 1, 0);
    send_payload(FB, 0);
    send_byte(pay_sum(), 1, 1);
    repeat (3) @(negedge clk);
    check("first_addr", 32'(wq.size() > 0 ? wq[0][18:8] : '0), 32'h400);
    check("last_addr", 32'(wq.size() == FB ? wq[FB-1][18:8] : '0), 32'h657);
    check_writes("count_frame", FB, 1'b1);
    exp_bank = 1'b1;
    check_events("count_frame", 1, 0, 1'b1);

    // Junk without A5, then 00 5A: no sync and no writes.
    for (int i = 0; i < 6; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'hA5);
      send_byte(b, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
    end
    send_byte(8'h00, 1, 0);
    send_byte(8'h5A, 1, 1);
    repeat (3) @(negedge clk);
    check_writes("nosync", 0, 1'b0);
    check_events("nosync", 0, 0, exp_bank);

    // Repeated A5 before 5A still syncs.
    fill_pay(1'b0);
    send_byte(8'hA5, 1, 0);
    send_byte(8'hA5, 1, 0);
    send_byte(8'h5A, 1, 0);
    good_frame("a5a5", 0);

    // Each byte held high for 50 cycles.
    fill_pay(1'b0);
    send_byte(8'hA5, 50, 0);
    send_byte(8'h5A, 50, 0);
    good_frame("held", 50);

    // Reset mid-frame after 300 payload bytes.
    fill_pay(1'b0);
    send_byte(8'hA5, 1, 0);
    send_byte(8'h5A, 1, 0);
    send_payload(300, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_addr", 32'(wr_addr), 32'd0);
    check("midrst_data", 32'(wr_data), 32'd0);
    check("midrst_pulses", 32'(frame_done | frame_err), 32'd0);
    check("midrst_bank", 32'(disp_bank), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_writes("midrst", 300, ~exp_bank);
    check_events("midrst", 0, 0, 1'b0);
    exp_bank = 1'b0;
    fill_pay(1'b0);
    send_byte(8'hA5, 1, 0);
    send_byte(8'h5A, 1, 0);
    good_frame("postrst", 0);

    check("exclusive", 32'(excl_viol), 32'd0);
    check("addr_hold", 32'(hold_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_loader.md
UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 600: payload bytes per frame (80x60 mono, 1 bpp).
REQ-002 SHALL have parameter ADDR_W, default 10: byte-index width; FRAME_BYTES <= 2**ADDR_W.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1_000_000: idle clocks allowed between bytes inside a frame.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port rx_ack  in  1  level from the byte receiver; high while a new byte is valid, possibly for many cycles.
REQ-007 SHALL have port rx_data  in  8  received byte, stable while rx_ack is high.
REQ-008 SHALL have port wr_en  out  1  frame-RAM write strobe, one cycle per payload byte.
REQ-009 SHALL have port wr_addr  out  ADDR_W+1  {write_bank, byte_index}.
REQ-010 SHALL have port wr_data  out  8  payload byte to store.
REQ-011 SHALL have port disp_bank  out  1  bank the display reads; the other bank is written.
REQ-012 SHALL have port frame_done  out  1  one-cycle pulse when a frame passes its checksum.
REQ-013 SHALL have port frame_err  out  1  one-cycle pulse on checksum mismatch or timeout.

Function
REQ-014 SHALL take one byte per rising edge of rx_ack (registered previous value); a held-high level SHALL count once.
REQ-015 SHALL implement the states HUNT0, HUNT1, PAYLOAD and CHECK.
REQ-016 SHALL move HUNT0->HUNT1 on byte 0xA5; other bytes stay in HUNT0.
REQ-017 SHALL move HUNT1->PAYLOAD on byte 0x5A; on 0xA5 stay in HUNT1; on any other byte return to HUNT0.
REQ-018 SHALL, on entering PAYLOAD, clear byte_index to 0 and the 8-bit checksum to 0.
REQ-019 SHALL, for each byte in PAYLOAD, assert wr_en on the cycle after the rx_ack edge, with wr_addr={~disp_bank, byte_index} and wr_data=byte, then increment byte_index and add the byte to the checksum modulo 256.
REQ-020 SHALL move PAYLOAD->CHECK after byte FRAME_BYTES-1 is written; byte_index SHALL never exceed FRAME_BYTES-1.
REQ-021 SHALL, in CHECK, compare the next byte with the checksum: on match toggle disp_bank and pulse frame_done; on mismatch pulse frame_err; both SHALL occur on the cycle after the rx_ack edge, then go to HUNT0.
REQ-022 SHALL count idle clocks in PAYLOAD and CHECK, clearing on every byte; on reaching TIMEOUT_CYC SHALL pulse frame_err, go to HUNT0 and leave disp_bank unchanged.
REQ-023 SHALL give the byte priority when a byte edge and timeout expiry fall on the same cycle.
REQ-024 SHALL never toggle disp_bank for a partial, timed-out or bad-checksum frame.
REQ-025 SHALL keep wr_en, frame_done and frame_err mutually exclusive, and low outside their stated cycles.
REQ-026 SHALL drive wr_addr and wr_data as don't-care-stable (hold last value) when wr_en is low.

Reset
REQ-027 SHALL, while rst is high, set state=HUNT0, byte_index=0, checksum=0, timeout counter=0, disp_bank=0, wr_en=0, frame_done=0, frame_err=0, wr_addr=0, wr_data=0 and the rx_ack history register to 1.
REQ-028 SHALL abandon any frame in progress when rst is asserted mid-frame, with no write or pulse on the reset cycle.

Structure
REQ-029 SHALL put the state encoding and the SYNC0=0xA5 and SYNC1=0x5A constants in package frame_loader_pkg.
REQ-030 SHALL place the rx_ack rising-edge detection in one sub-module, byte_strobe (clk, rst, level_in, pulse_out).

Verification
REQ-031 SHALL cover this case: A5 5A, bytes 0..FRAME_BYTES-1 (value = index mod 256), then the correct sum -> 600 writes to addresses 0x400..0x657, frame_done pulses once, and disp_bank goes 0->1.
REQ-032 SHALL cover this case: the same frame with the checksum byte XOR 0x01 -> frame_err pulses once and disp_bank stays 0.
REQ-033 SHALL cover this case: A5 A5 5A, then a frame -> sync is found and the frame is accepted; 00 5A -> no sync and no write.
REQ-034 SHALL cover this case: rx_ack held high 50 cycles per byte -> exactly one write per byte.
REQ-035 SHALL cover this case: 100 payload bytes, then TIMEOUT_CYC idle clocks (set to 1000 in the bench) -> frame_err at idle clock 1000, state HUNT0, and the next good frame still writes bank 1.
REQ-036 SHALL cover this case: rst pulsed after 300 payload bytes -> all outputs return to reset values, and a new full frame is accepted normally.
